nios2_sysid_arbiter: RTL and testbench



---
 rtl/nios2_sysid_pkg.sv | 21 ++
 rtl/nios2_sysid_rr_arb.sv | 43 ++++
 rtl/nios2_sysid_arbiter.sv | 109 ++++++++++
 tb/tb_nios2_sysid_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_sysid_pkg.sv
// Shared definitions for the system-ID arbiter: FSM encoding, word offsets,
// data width and master identifiers.
package nios2_sysid_pkg;

  localparam int SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  typedef enum logic [1:0] {
    CHK_ID = 2'd0,
    CHK_TS = 2'd1,
    RUN    = 2'd2
  } sysid_state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } master_e;

endpackage

// File: rtl/nios2_sysid_rr_arb.sv
// Two-way round-robin grant logic. On a tie the master that was not granted
// last wins; last_grant only moves when a grant is actually issued.
module nios2_sysid_rr_arb
  import nios2_sysid_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  master_e last_grant;

  // Combinational grant decision for the current cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        if (last_grant == GNT_M1) gnt0 = 1'b1;
        else                      gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Remember who was served last; m1 after reset so m0 wins the first tie
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GNT_M1;
    end else if (gnt0) begin
      last_grant <= GNT_M0;
    end else if (gnt1) begin
      last_grant <= GNT_M1;
    end
  end

endmodule

// File: rtl/nios2_sysid_arbiter.sv
// Arbiter between two Avalon-MM read masters and the combinational sysid
// slave. After reset it optionally reads both slave words and compares them
// with the expected values, then serves master reads round-robin with a
// fixed one-cycle read latency.
module nios2_sysid_arbiter
  import nios2_sysid_pkg::*;
#(
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID  = 32'd0,
  parameter logic [SYSID_DATA_W-1:0] EXPECTED_TS  = 32'd1516328916,
  parameter bit                      CHECK_ENABLE = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_address,
  input  logic                    m0_read,
  output logic                    m0_waitrequest,
  output logic [SYSID_DATA_W-1:0] m0_readdata,
  output logic                    m0_readdatavalid,
  input  logic                    m1_address,
  input  logic                    m1_read,
  output logic                    m1_waitrequest,
  output logic [SYSID_DATA_W-1:0] m1_readdata,
  output logic                    m1_readdatavalid,
  output logic                    s_address,
  input  logic [SYSID_DATA_W-1:0] s_readdata,
  output logic                    check_done,
  output logic                    check_pass
);

  sysid_state_e state;
  logic         id_ok;
  logic         run;
  logic         gnt0;
  logic         gnt1;

  // Reset is folded in so that, with the self-check disabled (state resets
  // straight to RUN), nothing is granted while reset is still asserted.
  assign run = (state == RUN) && !reset;

  nios2_sysid_rr_arb u_arb (
    .clock  (clock),
    .reset  (reset),
    .enable (run),
    .req0   (m0_read),
    .req1   (m1_read),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // Slave word select: fixed offsets during the self-check, granted master's
  // address in RUN, word 0 when idle
  always_comb begin
    s_address = SYSID_ADDR_ID;
    case (state)
      CHK_ID:  s_address = SYSID_ADDR_ID;
      CHK_TS:  s_address = SYSID_ADDR_TS;
      RUN: begin
        if (gnt0)      s_address = m0_address;
        else if (gnt1) s_address = m1_address;
      end
      default: s_address = SYSID_ADDR_ID;
    endcase
  end

  // Boot self-check FSM; with the check disabled the status flags come out of
  // reset already reporting a completed, passing check
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= CHECK_ENABLE ? CHK_ID : RUN;
      id_ok      <= 1'b0;
      check_done <= !CHECK_ENABLE;
      check_pass <= !CHECK_ENABLE;
    end else begin
      case (state)
        CHK_ID: begin
          id_ok <= (s_readdata == EXPECTED_ID);
          state <= CHK_TS;
        end
        CHK_TS: begin
          check_pass <= id_ok && (s_readdata == EXPECTED_TS);
          check_done <= 1'b1;
          state      <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Response registers: capture slave data for the granted master and pulse
  // its readdatavalid for exactly one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m0_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdata      <= '0;
      m1_readdatavalid <= 1'b0;
    end else begin
      m0_readdatavalid <= gnt0;
      m1_readdatavalid <= gnt1;
      if (gnt0) m0_readdata <= s_readdata;
      if (gnt1) m1_readdata <= s_readdata;
    end
  end

endmodule

// File: tb/tb_nios2_sysid_arbiter.sv
// Bench for nios2_sysid_arbiter: directed stimulus, expected read responses
// queued per master and popped by a monitor on every readdatavalid strobe.
module tb_nios2_sysid_arbiter;

  localparam logic [31:0] ID = 32'd0;
  localparam logic [31:0] TS = 32'd1516328916;

  logic        clock;
  logic        reset;
  logic        m0_address, m0_read, m0_waitrequest, m0_readdatavalid;
  logic        m1_address, m1_read, m1_waitrequest, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_address;
  logic [31:0] s_readdata;
  logic        check_done, check_pass;
  logic [31:0] ts_word;

  logic        d1_reset;
  logic        d1_m0_address, d1_m0_read, d1_m0_waitrequest, d1_m0_readdatavalid;
  logic        d1_m1_address, d1_m1_read, d1_m1_waitrequest, d1_m1_readdatavalid;
  logic [31:0] d1_m0_readdata, d1_m1_readdata;
  logic        d1_s_address;
  logic [31:0] d1_s_readdata;
  logic        d1_check_done, d1_check_pass;

  int          checks;
  int          errors;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // Slave models: combinational register file
  assign s_readdata    = s_address    ? ts_word : ID;
  assign d1_s_readdata = d1_s_address ? TS      : ID;

  nios2_sysid_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_readdata       (s_readdata),
    .check_done       (check_done),
    .check_pass       (check_pass)
  );

  nios2_sysid_arbiter #(.CHECK_ENABLE(1'b0)) dut_nochk (
    .clock            (clock),
    .reset            (d1_reset),
    .m0_address       (d1_m0_address),
    .m0_read          (d1_m0_read),
    .m0_waitrequest   (d1_m0_waitrequest),
    .m0_readdata      (d1_m0_readdata),
    .m0_readdatavalid (d1_m0_readdatavalid),
    .m1_address       (d1_m1_address),
    .m1_read          (d1_m1_read),
    .m1_waitrequest   (d1_m1_waitrequest),
    .m1_readdata      (d1_m1_readdata),
    .m1_readdatavalid (d1_m1_readdatavalid),
    .s_address        (d1_s_address),
    .s_readdata       (d1_s_readdata),
    .check_done       (d1_check_done),
    .check_pass       (d1_check_pass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (m0_readdatavalid) begin
        if (q0.size() == 0) chk1("m0_unexpected_valid", m0_readdatavalid, 1'b0);
        else                chk32("m0_readdata", m0_readdata, q0.pop_front());
      end
      if (m1_readdatavalid) begin
        if (q1.size() == 0) chk1("m1_unexpected_valid", m1_readdatavalid, 1'b0);
        else                chk32("m1_readdata", m1_readdata, q1.pop_front());
      end
      if (m0_readdatavalid && m1_readdatavalid)
        chk1("dual_valid", m0_readdatavalid & m1_readdatavalid, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic gm0;
    checks = 0;
    errors = 0;
    reset = 1'b1; ts_word = TS;
    m0_address = 1'b0; m0_read = 1'b0; m1_address = 1'b0; m1_read = 1'b0;
    d1_reset = 1'b1;
    d1_m0_address = 1'b0; d1_m0_read = 1'b0; d1_m1_address = 1'b0; d1_m1_read = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    @(negedge clock);
    chk1("rst_wr0", m0_waitrequest, 1'b1);
    chk1("rst_rdv0", m0_readdatavalid, 1'b0);
    chk32("rst_rd0", m0_readdata, 32'd0);
    chk1("rst_done", check_done, 1'b0);
    chk1("rst_pass", check_pass, 1'b0);
    repeat (2) step();
    reset = 1'b0;

    // Boot self-check
    @(negedge clock);
    chk1("boot0_wr0", m0_waitrequest, 1'b1);
    chk1("boot0_wr1", m1_waitrequest, 1'b1);
    chk1("boot0_saddr", s_address, 1'b0);
    chk1("boot0_done", check_done, 1'b0);
    @(negedge clock);
    chk1("boot1_wr0", m0_waitrequest, 1'b1);
    chk1("boot1_wr1", m1_waitrequest, 1'b1);
    chk1("boot1_saddr", s_address, 1'b1);
    chk1("boot1_done", check_done, 1'b0);
    @(negedge clock);
    chk1("boot2_done", check_done, 1'b1);
    chk1("boot2_pass", check_pass, 1'b1);
    chk1("idle_saddr", s_address, 1'b0);
    chk1("idle_wr0", m0_waitrequest, 1'b1);

    // m0 alone, address 1
    step();
    m0_read = 1'b1; m0_address = 1'b1;
    @(negedge clock);
    chk1("solo0_wr0", m0_waitrequest, 1'b0);
    chk1("solo0_wr1", m1_waitrequest, 1'b1);
    chk1("solo0_saddr", s_address, 1'b1);
    q0.push_back(TS);
    step();
    m0_read = 1'b0;
    @(negedge clock);
    chk1("solo0_rdv0", m0_readdatavalid, 1'b1);
    chk1("solo0_rdv1", m1_readdatavalid, 1'b0);
    @(negedge clock);
    chk1("solo0_strobe", m0_readdatavalid, 1'b0);
    chk32("solo0_hold", m0_readdata, TS);

    // m1 alone, address 0
    step();
    m1_read = 1'b1; m1_address = 1'b0;
    @(negedge clock);
    chk1("solo1_wr1", m1_waitrequest, 1'b0);
    q1.push_back(ID);
    step();
    m1_read = 1'b0;
    @(negedge clock);
    chk1("solo1_rdv1", m1_readdatavalid, 1'b1);

    // Contention: m0 addr 0, m1 addr 1 held for 4 cycles
    step();
    m0_read = 1'b1; m0_address = 1'b0; m1_read = 1'b1; m1_address = 1'b1;
    for (int i = 0; i < 4; i++) begin
      gm0 = ((i % 2) == 0);
      @(negedge clock);
      chk1("cont_wr0", m0_waitrequest, !gm0);
      chk1("cont_wr1", m1_waitrequest, gm0);
      chk1("cont_saddr", s_address, !gm0);
      if (gm0) q0.push_back(ID);
      else     q1.push_back(TS);
      if (i > 0) begin
        chk1("cont_rdv0", m0_readdatavalid, !gm0);
        chk1("cont_rdv1", m1_readdatavalid, gm0);
      end
      step();
      if (i == 3) begin
        m0_read = 1'b0; m1_read = 1'b0;
      end
    end
    @(negedge clock);
    chk1("cont_last_rdv1", m1_readdatavalid, 1'b1);
    chk1("cont_last_rdv0", m0_readdatavalid, 1'b0);

    // Reset right after an m1 accept drops the pending response
    step();
    m1_read = 1'b1; m1_address = 1'b1;
    @(negedge clock);
    chk1("rr_wr1", m1_waitrequest, 1'b0);
    step();
    m1_read = 1'b0; reset = 1'b1;
    @(negedge clock);
    chk1("rr_rdv1", m1_readdatavalid, 1'b0);
    chk32("rr_rd1", m1_readdata, 32'd0);
    chk1("rr_done", check_done, 1'b0);
    chk1("rr_wr0", m0_waitrequest, 1'b1);
    step();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 1'b1; m1_read = 1'b1; m1_address = 1'b0;
    @(negedge clock);
    chk1("rr_boot0_wr0", m0_waitrequest, 1'b1);
    chk1("rr_boot0_wr1", m1_waitrequest, 1'b1);
    chk1("rr_boot0_saddr", s_address, 1'b0);
    @(negedge clock);
    chk1("rr_boot1_wr0", m0_waitrequest, 1'b1);
    chk1("rr_boot1_saddr", s_address, 1'b1);
    @(negedge clock);
    chk1("rr_done2", check_done, 1'b1);
    chk1("rr_tie_wr0", m0_waitrequest, 1'b0);
    chk1("rr_tie_wr1", m1_waitrequest, 1'b1);
    q0.push_back(TS);
    step();
    m0_read = 1'b0; m1_read = 1'b0;
    @(negedge clock);
    chk1("rr_tie_rdv0", m0_readdatavalid, 1'b1);

    // Timestamp mismatch: check fails but access still works
    ts_word = TS + 32'd1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk1("mm_done", check_done, 1'b1);
    chk1("mm_pass", check_pass, 1'b0);
    step();
    m0_read = 1'b1; m0_address = 1'b1;
    @(negedge clock);
    chk1("mm_wr0", m0_waitrequest, 1'b0);
    q0.push_back(TS + 32'd1);
    step();
    m0_read = 1'b0;
    @(negedge clock);
    chk1("mm_rdv0", m0_readdatavalid, 1'b1);

    // Self-check disabled instance
    d1_m1_read = 1'b1; d1_m1_address = 1'b1;
    @(negedge clock);
    chk1("nc_rst_wr1", d1_m1_waitrequest, 1'b1);
    step();
    d1_reset = 1'b0;
    @(negedge clock);
    chk1("nc_done", d1_check_done, 1'b1);
    chk1("nc_pass", d1_check_pass, 1'b1);
    chk1("nc_wr1", d1_m1_waitrequest, 1'b0);
    chk1("nc_saddr", d1_s_address, 1'b1);
    step();
    d1_m1_read = 1'b0;
    @(negedge clock);
    chk1("nc_rdv1", d1_m1_readdatavalid, 1'b1);
    chk32("nc_rd1", d1_m1_readdata, TS);
    chk1("nc_rdv0", d1_m0_readdatavalid, 1'b0);

    @(negedge clock);
    chk32("q0_drained", 32'(q0.size()), 32'd0);
    chk32("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
